operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
Upstream operand-entry stage for the lab05b four-operand datapath. It captures four WIDTH-bit operands one at a time from a shared switch bus (din), using a push-button load. It holds the operands on a, b, c and d. On a go button it fires a multi-cycle start pulse to the downstream block. Both button inputs are asynchronous and are synchronised and edge-detected inside this block.

Parameters:
WIDTH, 8, width of din and of each operand output
START_LEN, 2, number of clk cycles start is held high per fire; legal range 1..255

Ports:
clk  in  1  system clock, rising edge
clean  in  1  reset; asynchronous, active-high
din  in  WIDTH  operand value from switches; must be stable while load is high
load  in  1  asynchronous push-button; each rising edge captures one operand
go  in  1  asynchronous push-button; a rising edge fires start when all four operands are held
a  out  WIDTH  operand 0 (first captured)
b  out  WIDTH  operand 1
c  out  WIDTH  operand 2
d  out  WIDTH  operand 3 (last captured)
start  out  1  start pulse to the downstream block, exactly START_LEN cycles long
count  out  3  number of operands captured in the current set, 0..4
ready  out  1  high while all four operands are held and the block is waiting for go
busy  out  1  high while start is being driven

Behaviour:
- Reset (clean=1, takes effect asynchronously with no clock edge):
  - a, b, c, d = 0; start = 0; count = 0; ready = 0; busy = 0.
  - Synchroniser and edge registers = 0; state = FILL.
- Input conditioning:
  - load and go each pass through a 2-flop synchroniser, then a previous-value register.
  - edge = synced & ~prev.
  - If a button is first sampled high at clk edge k, its edge is acted on at edge k+2.
  - A held button produces exactly one edge. A pulse shorter than one clk period may be missed; that is legal.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- State FILL:
  - On a load edge, din is written to the operand selected by count (0→a, 1→b, 2→c, 3→d), and count increments.
  - When the capture takes count from 3 to 4, the state moves to READY on the same edge.
  - go edges are ignored.
- State READY (ready=1, count=4):
  - load edges are ignored; operands do not change.
  - On a go edge: the state moves to FIRE, start=1, busy=1, ready=0, and the fire counter loads START_LEN-1.
  - start is therefore first high in the cycle after edge k+2.
- State FIRE (start=busy=1):
  - The fire counter decrements each cycle.
  - On the edge where the fire counter is 0: start=0, busy=0, count=0, state returns to FILL.
  - start is high for exactly START_LEN cycles.
  - load and go edges occurring during FIRE are discarded.
  - a..d hold their values throughout FIRE.
- Operand retention:
  - a..d keep their values after FIRE until each is individually overwritten by the next set.
  - They are never cleared except by reset.
  - The downstream block must sample operands at start.
- Simultaneous events:
  - load edge and go edge in the same cycle in READY: go wins, load is dropped.
  - In FILL with count=3: load is captured and go is ignored, so a second go press is needed.
- Reset mid-operation:
  - Any state returns to FILL with all outputs 0 immediately.
  - A button held through the release of reset produces a fresh edge two cycles after release, because the prev register resets to 0.
- No wrap-around: count never exceeds 4. Extra loads are ignored, not wrapped.

Test Plan:
1. Reset: with clean=1, toggle load and go -> a=b=c=d=0, start=0, count=0, ready=0, busy=0. Then clean=0 with no stimulus -> outputs unchanged.
2. Fill: press load (2 cycles high, 4 cycles low) four times with din=0x05, 0x11, 0x1B, 0x27 -> a=0x05, b=0x11, c=0x1B, d=0x27. count steps 1,2,3,4, each update at the 3rd edge after load rises. ready=1 after the 4th press.
3. Fire: in READY, raise go -> start=busy=1 for exactly 2 cycles, starting the cycle after the 3rd edge from go rising. Then count=0, ready=0, and a..d still 0x05/0x11/0x1B/0x27.
4. Held button: hold load high for 10 cycles with din=0x3C in FILL -> exactly one capture (a=0x3C, count=1). A 5th load press in READY with din=0xFF -> no change, count stays 4.
5. Collision: in READY, load and go rise on the same cycle -> fire occurs, operands unchanged. With START_LEN=1 -> start is high for exactly 1 cycle.
6. Async reset mid-FIRE: assert clean between clk edges while start=1 -> start, busy and a..d drop to 0 before the next clk edge. After release, count=0 and the state is FILL.

Source files
------------

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - four-operand entry stage with push-button load/go and timed start pulse
//
// Captures four WIDTH-bit operands one at a time from the shared din bus on
// rising edges of the load button. Once all four are held, a rising edge of
// the go button fires start for exactly START_LEN clk cycles.
//
// Ports:
//   clk    in   rising-edge system clock
//   clean  in   asynchronous active-high reset
//   din    in   operand value from switches (stable while load is high)
//   load   in   asynchronous button, one capture per rising edge
//   go     in   asynchronous button, fires start when four operands are held
//   a..d   out  captured operands 0..3
//   start  out  start pulse to downstream block, START_LEN cycles
//   count  out  operands captured in the current set, 0..4
//   ready  out  all four operands held, waiting for go
//   busy   out  high while start is driven

module operand_loader #(
  parameter int WIDTH     = 8,
  parameter int START_LEN = 2
) (
  input  logic             clk,
  input  logic             clean,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             go,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             start,
  output logic [2:0]       count,
  output logic             ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    FIRE  = 2'd2
  } state_t;

  localparam logic [7:0] FIRE_INIT = 8'(START_LEN - 1);

  state_t state, state_d;

  logic load_s1, load_s2, load_prev;
  logic go_s1, go_s2, go_prev;
  logic load_edge, go_edge;

  logic [7:0]       fire_cnt, fire_d;
  logic [WIDTH-1:0] a_d, b_d, c_d, d_d;
  logic [2:0]       count_d;
  logic             start_d, busy_d, ready_d;

  // Edges are taken after the second synchroniser stage, so a button first
  // seen at edge k is acted on at edge k+2; a held button yields one edge.
  assign load_edge = load_s2 & ~load_prev;
  assign go_edge   = go_s2 & ~go_prev;

  always_ff @(posedge clk or posedge clean) begin
    if (clean) begin
      load_s1   <= 1'b0;
      load_s2   <= 1'b0;
      load_prev <= 1'b0;
      go_s1     <= 1'b0;
      go_s2     <= 1'b0;
      go_prev   <= 1'b0;
      state     <= FILL;
      fire_cnt  <= 8'd0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      count     <= 3'd0;
      start     <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      load_s1   <= load;
      load_s2   <= load_s1;
      load_prev <= load_s2;
      go_s1     <= go;
      go_s2     <= go_s1;
      go_prev   <= go_s2;
      state     <= state_d;
      fire_cnt  <= fire_d;
      a         <= a_d;
      b         <= b_d;
      c         <= c_d;
      d         <= d_d;
      count     <= count_d;
      start     <= start_d;
      busy      <= busy_d;
      ready     <= ready_d;
    end
  end

  always_comb begin
    state_d = state;
    fire_d  = fire_cnt;
    a_d     = a;
    b_d     = b;
    c_d     = c;
    d_d     = d;
    count_d = count;
    start_d = 1'b0;
    busy_d  = 1'b0;
    ready_d = 1'b0;

    case (state)
      FILL: begin
        // go is deliberately ignored here, even on the capture that fills the set
        if (load_edge) begin
          case (count[1:0])
            2'd0:    a_d = din;
            2'd1:    b_d = din;
            2'd2:    c_d = din;
            default: d_d = din;
          endcase
          count_d = count + 3'd1;
          if (count == 3'd3) state_d = READY;
        end
      end
      READY: begin
        // load edges are dropped; go wins a same-cycle collision by construction
        if (go_edge) begin
          state_d = FIRE;
          fire_d  = FIRE_INIT;
        end
      end
      FIRE: begin
        if (fire_cnt == 8'd0) begin
          state_d = FILL;
          count_d = 3'd0;
        end else begin
          fire_d = fire_cnt - 8'd1;
        end
      end
      default: state_d = FILL;
    endcase

    // Outputs are decoded from the next state and registered with it.
    ready_d = (state_d == READY);
    start_d = (state_d == FIRE);
    busy_d  = (state_d == FIRE);
  end

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed self-checking bench for operand_loader

module tb_operand_loader;

  logic       clk;
  logic       clean;
  logic [7:0] din;
  logic       load;
  logic       go;

  logic [7:0] a, b, c, d;
  logic       start, ready, busy;
  logic [2:0] count;

  logic [7:0] a2, b2, c2, d2;
  logic       start2, ready2, busy2;
  logic [2:0] count2;

  int vectors;
  int miscompares;
  int hi1, hi2;

  operand_loader #(.WIDTH(8), .START_LEN(2)) dut (
    .clk(clk), .clean(clean), .din(din), .load(load), .go(go),
    .a(a), .b(b), .c(c), .d(d),
    .start(start), .count(count), .ready(ready), .busy(busy)
  );

  operand_loader #(.WIDTH(8), .START_LEN(1)) dut1 (
    .clk(clk), .clean(clean), .din(din), .load(load), .go(go),
    .a(a2), .b(b2), .c(c2), .d(d2),
    .start(start2), .count(count2), .ready(ready2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press_load(input logic [7:0] val, input int hi);
    din  = val;
    load = 1'b1;
    repeat (hi) @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Raise go and count start-high cycles of both instances over a fixed window.
  task automatic fire_and_measure(output int w1, output int w2);
    w1 = 0;
    w2 = 0;
    go = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (start)  w1++;
      if (start2) w2++;
    end
    go = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clean = 1'b1;
    din   = 8'h00;
    load  = 1'b0;
    go    = 1'b0;

    // 1. reset holds everything at zero despite button activity
    repeat (3) begin
      @(negedge clk); load = 1'b1; go = 1'b1;
      @(negedge clk); load = 1'b0; go = 1'b0;
    end
    check("rst_a", a, 0);
    check("rst_d", d, 0);
    check("rst_start", start, 0);
    check("rst_count", count, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    clean = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_count", count, 0);
    check("idle_ready", ready, 0);
    check("idle_start", start, 0);

    // 2. fill; first press checks the k+2 capture latency
    din  = 8'h05;
    load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lat_before", count, 0);
    load = 1'b0;
    @(negedge clk);
    check("lat_after", count, 1);
    check("fill_a", a, 8'h05);
    repeat (3) @(negedge clk);
    press_load(8'h11, 2);
    check("fill_cnt2", count, 2);
    check("fill_ready2", ready, 0);
    press_load(8'h1B, 2);
    check("fill_cnt3", count, 3);
    press_load(8'h27, 2);
    check("fill_cnt4", count, 4);
    check("fill_ready", ready, 1);
    check("fill_b", b, 8'h11);
    check("fill_c", c, 8'h1B);
    check("fill_d", d, 8'h27);

    // 3. fire timing: start first high after the 3rd edge from go rising
    go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("fire_pre", start, 0);
    @(negedge clk);
    check("fire_c1", start, 1);
    check("fire_busy", busy, 1);
    check("fire_rdy", ready, 0);
    check("fire1_c1", start2, 1);
    @(negedge clk);
    check("fire_c2", start, 1);
    check("fire1_c2", start2, 0);
    @(negedge clk);
    check("fire_end", start, 0);
    check("fire_busy_end", busy, 0);
    check("fire_count", count, 0);
    check("fire_ready", ready, 0);
    go = 1'b0;
    repeat (3) @(negedge clk);
    check("keep_a", a, 8'h05);
    check("keep_b", b, 8'h11);
    check("keep_c", c, 8'h1B);
    check("keep_d", d, 8'h27);

    // 4. held load gives one capture; a fifth press in READY is ignored
    press_load(8'h3C, 10);
    check("held_a", a, 8'h3C);
    check("held_count", count, 1);
    check("held_b", b, 8'h11);
    press_load(8'h01, 2);
    press_load(8'h02, 2);
    press_load(8'h03, 2);
    check("refill_ready", ready, 1);
    press_load(8'hFF, 2);
    check("extra_count", count, 4);
    check("extra_a", a, 8'h3C);
    check("extra_d", d, 8'h03);

    // 5. load and go together in READY: fire wins, operands untouched
    din  = 8'hAA;
    load = 1'b1;
    fire_and_measure(hi1, hi2);
    load = 1'b0;
    repeat (4) @(negedge clk);
    check("coll_width", hi1, 2);
    check("coll_width1", hi2, 1);
    check("coll_a", a, 8'h3C);
    check("coll_b", b, 8'h01);
    check("coll_d", d, 8'h03);
    check("coll_count", count, 0);

    // 6. asynchronous reset in the middle of FIRE
    press_load(8'h10, 2);
    press_load(8'h20, 2);
    press_load(8'h30, 2);
    press_load(8'h40, 2);
    check("pre6_ready", ready, 1);
    go = 1'b1;
    repeat (3) @(negedge clk);
    check("pre6_start", start, 1);
    #2 clean = 1'b1;
    #1;
    check("ar_start", start, 0);
    check("ar_busy", busy, 0);
    check("ar_a", a, 0);
    check("ar_d", d, 0);
    go = 1'b0;
    @(negedge clk);
    clean = 1'b0;
    repeat (3) @(negedge clk);
    check("ar_count", count, 0);
    check("ar_ready", ready, 0);
    press_load(8'h42, 2);
    check("ar_fill_cnt", count, 1);
    check("ar_fill_a", a, 8'h42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
